// File: rtl/alu_exc_if.sv
// Bundle of signals between the ALU/control unit and alu_exception_unit.
// master = pipeline/control side, slave = the exception unit.
interface alu_exc_if #(
  parameter int PC_WIDTH = 32
);
  logic [7:0]          ALU_status_in;
  logic                status_valid;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                en_we;
  logic [7:0]          en_wdata;
  logic                sticky_clr;
  logic                exc_ack;

  logic [7:0]          status_reg;
  logic [7:0]          sticky_flags;
  logic [7:0]          exc_en;
  logic                exc_req;
  logic [2:0]          exc_cause;
  logic [PC_WIDTH-1:0] epc;
  logic                stall;
  logic                flush;
  logic [7:0]          exc_count;

  modport master (
    output ALU_status_in, status_valid, instr_pc, en_we, en_wdata, sticky_clr, exc_ack,
    input  status_reg, sticky_flags, exc_en, exc_req, exc_cause, epc, stall, flush, exc_count
  );

  modport slave (
    input  ALU_status_in, status_valid, instr_pc, en_we, en_wdata, sticky_clr, exc_ack,
    output status_reg, sticky_flags, exc_en, exc_req, exc_cause, epc, stall, flush, exc_count
  );
endinterface

// File: rtl/alu_exception_unit.sv
// Samples retiring ALU status, keeps last/sticky flags and turns enabled error
// flags into a prioritised exception request with EPC, stall and flush.
module alu_exception_unit #(
  parameter int          PC_WIDTH = 32,
  parameter logic [7:0]  EN_RESET = 8'b0100_1100
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_exc_if.slave bus
);

  localparam logic [7:0] STATUS_MASK = 8'hFC;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_OVF  = 3'd1;
  localparam logic [2:0] CAUSE_ADDR = 3'd2;
  localparam logic [2:0] CAUSE_DIV  = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_status;
  logic [7:0]          r_sticky;
  logic [7:0]          r_exc_en;
  logic                r_exc_req;
  logic [2:0]          r_exc_cause;
  logic [PC_WIDTH-1:0] r_epc;
  logic                r_stall;
  logic                r_flush;
  logic [7:0]          r_exc_count;

  logic [7:0] w_status_masked;
  logic       w_accept;
  logic       w_err_ovf;
  logic       w_err_addr;
  logic       w_err_div;
  logic       w_err_any;
  logic [2:0] w_cause;

  assign w_status_masked = bus.ALU_status_in & STATUS_MASK;
  assign w_accept        = (r_state == S_IDLE) && bus.status_valid;

  // Error detection uses the registered mask, so a same-cycle en_we sees the old mask.
  assign w_err_ovf  = bus.ALU_status_in[6] & r_exc_en[6];
  assign w_err_addr = bus.ALU_status_in[3] & r_exc_en[3];
  assign w_err_div  = bus.ALU_status_in[2] & r_exc_en[2];
  assign w_err_any  = w_err_ovf | w_err_addr | w_err_div;

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_err_addr)     w_cause = CAUSE_ADDR;
    else if (w_err_div) w_cause = CAUSE_DIV;
    else if (w_err_ovf) w_cause = CAUSE_OVF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_status    <= 8'h00;
      r_sticky    <= 8'h00;
      r_exc_en    <= EN_RESET;
      r_exc_req   <= 1'b0;
      r_exc_cause <= CAUSE_NONE;
      r_epc       <= '0;
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_exc_count <= 8'h00;
    end else begin
      if (bus.en_we) begin
        r_exc_en <= bus.en_wdata & STATUS_MASK;
      end

      // Clear takes effect before the OR of a coincident accepted status.
      if (bus.sticky_clr) begin
        r_sticky <= w_accept ? w_status_masked : 8'h00;
      end else if (w_accept) begin
        r_sticky <= r_sticky | w_status_masked;
      end

      case (r_state)
        S_IDLE: begin
          r_flush <= 1'b0;
          if (w_accept) begin
            r_status <= w_status_masked;
            if (w_err_any) begin
              r_epc       <= bus.instr_pc;
              r_exc_cause <= w_cause;
              r_exc_req   <= 1'b1;
              r_stall     <= 1'b1;
              r_state     <= S_PENDING;
            end
          end
        end

        S_PENDING: begin
          if (bus.exc_ack) begin
            r_exc_req <= 1'b0;
            r_flush   <= 1'b1;
            r_state   <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          r_flush     <= 1'b0;
          r_stall     <= 1'b0;
          r_exc_cause <= CAUSE_NONE;
          if (r_exc_count != 8'hFF) begin
            r_exc_count <= r_exc_count + 8'd1;
          end
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_exc_req   <= 1'b0;
          r_stall     <= 1'b0;
          r_flush     <= 1'b0;
          r_exc_cause <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign bus.status_reg   = r_status;
  assign bus.sticky_flags = r_sticky;
  assign bus.exc_en       = r_exc_en;
  assign bus.exc_req      = r_exc_req;
  assign bus.exc_cause    = r_exc_cause;
  assign bus.epc          = r_epc;
  assign bus.stall        = r_stall;
  assign bus.flush        = r_flush;
  assign bus.exc_count    = r_exc_count;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Directed self-checking bench for alu_exception_unit.
module tb_alu_exception_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_exc_if #(.PC_WIDTH(32)) bus ();

  alu_exception_unit #(
    .PC_WIDTH(32),
    .EN_RESET(8'b0100_1100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_status(input logic [7:0] st, input logic [31:0] pc);
    bus.status_valid  = 1'b1;
    bus.ALU_status_in = st;
    bus.instr_pc      = pc;
    cyc();
    bus.status_valid  = 1'b0;
    $display("[TB] status_valid status=%02h pc=%08h -> req=%0b cause=%0d epc=%08h",
             st, pc, bus.exc_req, bus.exc_cause, bus.epc);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.status_reg !== 8'h00) begin n_fail++; $display("FAIL rst_status: got %02h exp 00", bus.status_reg); end
    n_tests++; if (bus.sticky_flags !== 8'h00) begin n_fail++; $display("FAIL rst_sticky: got %02h exp 00", bus.sticky_flags); end
    n_tests++; if (bus.exc_en !== 8'h4C) begin n_fail++; $display("FAIL rst_en: got %02h exp 4C", bus.exc_en); end
    n_tests++; if (bus.exc_req !== 1'b0 || bus.stall !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got req=%0b stall=%0b flush=%0b exp 0 0 0", bus.exc_req, bus.stall, bus.flush); end
    n_tests++; if (bus.exc_cause !== 3'd0 || bus.epc !== 32'h0 || bus.exc_count !== 8'h00) begin n_fail++; $display("FAIL rst_misc: got cause=%0d epc=%08h cnt=%0d exp 0 0 0", bus.exc_cause, bus.epc, bus.exc_count); end
    #16 rst_n = 1'b1;
    cyc();
    $display("[TB] reset released");
  endtask

  task automatic test_nonerror();
    drive_status(8'h93, 32'h0000_0100);
    n_tests++; if (bus.status_reg !== 8'h90) begin n_fail++; $display("FAIL nonerr_status: got %02h exp 90", bus.status_reg); end
    n_tests++; if (bus.sticky_flags !== 8'h90) begin n_fail++; $display("FAIL nonerr_sticky: got %02h exp 90", bus.sticky_flags); end
    n_tests++; if (bus.exc_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL nonerr_req: got req=%0b stall=%0b exp 0 0", bus.exc_req, bus.stall); end
  endtask

  task automatic test_div0();
    drive_status(8'h04, 32'h0040_0010);
    n_tests++; if (bus.exc_req !== 1'b1 || bus.stall !== 1'b1 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL div0_req: got req=%0b stall=%0b flush=%0b exp 1 1 0", bus.exc_req, bus.stall, bus.flush); end
    n_tests++; if (bus.exc_cause !== 3'd3) begin n_fail++; $display("FAIL div0_cause: got %0d exp 3", bus.exc_cause); end
    n_tests++; if (bus.epc !== 32'h0040_0010) begin n_fail++; $display("FAIL div0_epc: got %08h exp 00400010", bus.epc); end
    cyc();
    n_tests++; if (bus.exc_req !== 1'b1 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL div0_hold: got req=%0b stall=%0b exp 1 1", bus.exc_req, bus.stall); end
    bus.exc_ack = 1'b1;
    cyc();
    bus.exc_ack = 1'b0;
    $display("[TB] ack -> flush=%0b req=%0b stall=%0b", bus.flush, bus.exc_req, bus.stall);
    n_tests++; if (bus.flush !== 1'b1 || bus.exc_req !== 1'b0 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL div0_flush: got flush=%0b req=%0b stall=%0b exp 1 0 1", bus.flush, bus.exc_req, bus.stall); end
    cyc();
    n_tests++; if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.exc_cause !== 3'd0) begin n_fail++; $display("FAIL div0_idle: got flush=%0b stall=%0b cause=%0d exp 0 0 0", bus.flush, bus.stall, bus.exc_cause); end
    n_tests++; if (bus.exc_count !== 8'd1) begin n_fail++; $display("FAIL div0_count: got %0d exp 1", bus.exc_count); end
  endtask

  task automatic test_ack_idle();
    bus.exc_ack = 1'b1;
    cyc();
    bus.exc_ack = 1'b0;
    $display("[TB] stray ack in IDLE -> flush=%0b", bus.flush);
    n_tests++; if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.exc_count !== 8'd1) begin n_fail++; $display("FAIL ackidle: got flush=%0b stall=%0b cnt=%0d exp 0 0 1", bus.flush, bus.stall, bus.exc_count); end
  endtask

  task automatic test_priority();
    drive_status(8'h4C, 32'h0000_00A0);
    n_tests++; if (bus.exc_cause !== 3'd2) begin n_fail++; $display("FAIL prio_cause: got %0d exp 2", bus.exc_cause); end
    drive_status(8'h04, 32'h0000_00B0);
    n_tests++; if (bus.epc !== 32'h0000_00A0) begin n_fail++; $display("FAIL prio_epc_hold: got %08h exp 000000A0", bus.epc); end
    n_tests++; if (bus.status_reg !== 8'h4C) begin n_fail++; $display("FAIL prio_status_hold: got %02h exp 4C", bus.status_reg); end
    n_tests++; if (bus.sticky_flags !== 8'hDC) begin n_fail++; $display("FAIL prio_sticky: got %02h exp DC", bus.sticky_flags); end
    n_tests++; if (bus.exc_cause !== 3'd2) begin n_fail++; $display("FAIL prio_cause_hold: got %0d exp 2", bus.exc_cause); end
    bus.exc_ack = 1'b1;
    cyc();
    bus.exc_ack = 1'b0;
    // overflow offered during FLUSH must be dropped
    drive_status(8'h40, 32'h0000_00C0);
    cyc();
    n_tests++; if (bus.exc_req !== 1'b0 || bus.status_reg !== 8'h4C || bus.epc !== 32'h0000_00A0) begin n_fail++; $display("FAIL flush_drop: got req=%0b status=%02h epc=%08h exp 0 4C 000000A0", bus.exc_req, bus.status_reg, bus.epc); end
    n_tests++; if (bus.exc_count !== 8'd2) begin n_fail++; $display("FAIL prio_count: got %0d exp 2", bus.exc_count); end
  endtask

  task automatic test_mask();
    bus.en_we    = 1'b1;
    bus.en_wdata = 8'h0B;
    drive_status(8'h40, 32'h0000_00D0);
    bus.en_we    = 1'b0;
    n_tests++; if (bus.exc_req !== 1'b1 || bus.exc_cause !== 3'd1) begin n_fail++; $display("FAIL mask_oldmask: got req=%0b cause=%0d exp 1 1", bus.exc_req, bus.exc_cause); end
    n_tests++; if (bus.exc_en !== 8'h08) begin n_fail++; $display("FAIL mask_en: got %02h exp 08", bus.exc_en); end
    bus.exc_ack = 1'b1;
    cyc();
    bus.exc_ack = 1'b0;
    cyc();
    bus.sticky_clr = 1'b1;
    cyc();
    bus.sticky_clr = 1'b0;
    n_tests++; if (bus.sticky_flags !== 8'h00) begin n_fail++; $display("FAIL mask_clr: got %02h exp 00", bus.sticky_flags); end
    drive_status(8'h40, 32'h0000_00E0);
    n_tests++; if (bus.exc_req !== 1'b0 || bus.epc !== 32'h0000_00D0) begin n_fail++; $display("FAIL mask_newmask: got req=%0b epc=%08h exp 0 000000D0", bus.exc_req, bus.epc); end
    n_tests++; if (bus.sticky_flags !== 8'h40 || bus.status_reg !== 8'h40) begin n_fail++; $display("FAIL mask_sticky: got sticky=%02h status=%02h exp 40 40", bus.sticky_flags, bus.status_reg); end
    n_tests++; if (bus.exc_count !== 8'd3) begin n_fail++; $display("FAIL mask_count: got %0d exp 3", bus.exc_count); end
  endtask

  task automatic test_reset_mid_pending();
    drive_status(8'h08, 32'h0000_00F0);
    n_tests++; if (bus.exc_req !== 1'b1 || bus.exc_cause !== 3'd2) begin n_fail++; $display("FAIL rmp_req: got req=%0b cause=%0d exp 1 2", bus.exc_req, bus.exc_cause); end
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-PENDING -> req=%0b en=%02h", bus.exc_req, bus.exc_en);
    n_tests++; if (bus.exc_req !== 1'b0 || bus.stall !== 1'b0 || bus.flush !== 1'b0 || bus.exc_cause !== 3'd0) begin n_fail++; $display("FAIL rmp_ctrl: got req=%0b stall=%0b flush=%0b cause=%0d exp 0 0 0 0", bus.exc_req, bus.stall, bus.flush, bus.exc_cause); end
    n_tests++; if (bus.epc !== 32'h0 || bus.status_reg !== 8'h00 || bus.sticky_flags !== 8'h00 || bus.exc_count !== 8'h00) begin n_fail++; $display("FAIL rmp_regs: got epc=%08h status=%02h sticky=%02h cnt=%0d exp 0 0 0 0", bus.epc, bus.status_reg, bus.sticky_flags, bus.exc_count); end
    n_tests++; if (bus.exc_en !== 8'h4C) begin n_fail++; $display("FAIL rmp_en: got %02h exp 4C", bus.exc_en); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst_n = 1'b1;
      cyc();
      n_tests++; if (bus.flush !== 1'b0 || bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL rmp_noflush[%0d]: got flush=%0b req=%0b exp 0 0", i, bus.flush, bus.exc_req); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      bus.status_valid  = 1'b1;
      bus.ALU_status_in = 8'h04;
      bus.instr_pc      = 32'h0001_0000 + i;
      cyc();
      bus.status_valid  = 1'b0;
      bus.exc_ack       = 1'b1;
      cyc();
      bus.exc_ack       = 1'b0;
      cyc();
      if (i == 253) begin
        n_tests++; if (bus.exc_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d exp 254", bus.exc_count); end
      end
      if (i == 254) begin
        n_tests++; if (bus.exc_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d exp 255", bus.exc_count); end
      end
    end
    $display("[TB] 260 exceptions taken -> exc_count=%0d", bus.exc_count);
    n_tests++; if (bus.exc_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d exp 255", bus.exc_count); end
  endtask

  task automatic test_sticky_clr();
    n_tests++; if (bus.sticky_flags !== 8'h04) begin n_fail++; $display("FAIL stk_pre: got %02h exp 04", bus.sticky_flags); end
    bus.sticky_clr = 1'b1;
    drive_status(8'h20, 32'h0000_0200);
    bus.sticky_clr = 1'b0;
    n_tests++; if (bus.sticky_flags !== 8'h20 || bus.status_reg !== 8'h20) begin n_fail++; $display("FAIL stk_clr_or: got sticky=%02h status=%02h exp 20 20", bus.sticky_flags, bus.status_reg); end
    n_tests++; if (bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL stk_noexc: got %0b exp 0", bus.exc_req); end
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    bus.ALU_status_in = 8'h00;
    bus.status_valid  = 1'b0;
    bus.instr_pc      = 32'h0;
    bus.en_we         = 1'b0;
    bus.en_wdata      = 8'h00;
    bus.sticky_clr    = 1'b0;
    bus.exc_ack       = 1'b0;

    test_reset();
    test_nonerror();
    test_div0();
    test_ack_idle();
    test_priority();
    test_mask();
    test_reset_mid_pending();
    test_saturation();
    test_sticky_clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exception_unit.md
# alu_exception_unit

Sequential consumer of the ALU's 8-bit status vector in the simplified MIPS datapath. Samples the status of each retiring EX-stage instruction and holds the last-status and sticky-flag registers. Converts enabled error flags into a prioritised exception request with cause, EPC and pipeline stall/flush. It sits between the ALU and the control unit, and handshakes with the control unit's exception entry logic.

## Interface
- PC_WIDTH, 32, width of instr_pc and epc.
- EN_RESET, 8'b0100_1100, reset value of exception-enable mask (overflow, invalid address, divide by zero enabled).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ALU_status_in  in  8  ALU status: [7] zero, [6] overflow, [5] carry, [4] negative, [3] invalid address, [2] divide by zero, [1:0] reserved (ignored).
- status_valid  in  1  one-cycle pulse: ALU_status_in and instr_pc belong to a retiring instruction.
- instr_pc  in  PC_WIDTH  PC of the instruction qualified by status_valid.
- en_we  in  1  write strobe for the enable mask.
- en_wdata  in  8  new enable mask; bits [1:0] are forced to 0.
- sticky_clr  in  1  clears sticky_flags.
- exc_ack  in  1  control unit accepts the pending exception.
- status_reg  out  8  status of the last accepted instruction, bits [1:0] are 0.
- sticky_flags  out  8  OR-accumulation of accepted status since reset or clear.
- exc_en  out  8  current enable mask.
- exc_req  out  1  exception pending.
- exc_cause  out  3  0 none, 1 overflow, 2 invalid address, 3 divide by zero.
- epc  out  PC_WIDTH  PC of the faulting instruction.
- stall  out  1  freeze the pipeline front end.
- flush  out  1  one-cycle pulse: squash in-flight instructions.
- exc_count  out  8  saturating count of exceptions taken.

## Operation
- FSM has three states: IDLE, PENDING, FLUSH.
- IDLE, status_valid=1: status_reg <= ALU_status_in & 8'hFC, and sticky_flags |= the same masked value.
  - err = ALU_status_in & exc_en & 8'b0100_1100.
  - If err != 0: epc <= instr_pc, latch exc_cause, go to PENDING.
- Cause priority is invalid address (2), then divide by zero (3), then overflow (1). Only the highest-priority cause is reported.
- PENDING: exc_req=1, stall=1. status_valid is ignored; status_reg, sticky_flags and epc hold. exc_ack=1 moves to FLUSH.
- FLUSH lasts one cycle: exc_req=0, stall=1, flush=1. exc_count increments, saturating at 255. Next state is IDLE, and exc_cause clears to 0.
- exc_ack outside PENDING is ignored.
- en_we is accepted in any state. When en_we and status_valid arrive in the same cycle, the status is evaluated with the old mask.
- sticky_clr is accepted in any state. When it coincides with an accepted status_valid, sticky_flags <= the new masked status (clear first, then OR).
- Non-error flags (zero, carry, negative) only update the status registers and never cause an exception.

## Timing
- Reset values: status_reg 0, sticky_flags 0, exc_en EN_RESET, exc_req 0, exc_cause 0, epc 0, stall 0, flush 0, exc_count 0, state IDLE.
- All outputs are registered, or decoded from state only; there is no combinational path from inputs to outputs.
- status_valid sampled at edge N: status_reg and epc are valid after edge N. exc_req and stall are high in cycle N+1.
- exc_ack is sampled at the edge ending a PENDING cycle. An ack in the first PENDING cycle gives FLUSH in the next cycle and IDLE in the cycle after.
- The minimum exception lifetime is 2 cycles of stall: 1 cycle of PENDING plus 1 cycle of FLUSH.
- status_valid in the FLUSH cycle is dropped.
- Asynchronous reset mid-PENDING or mid-FLUSH clears everything immediately, with no flush pulse. exc_en returns to EN_RESET.

## Test plan
- Reset, then status_valid with ALU_status_in=8'h90 (zero and negative) -> status_reg=8'h90, sticky_flags=8'h90, exc_req stays 0.
- Divide by zero: ALU_status_in=8'h04, instr_pc=32'h0040_0010 -> next cycle exc_req=1, exc_cause=3, epc=32'h0040_0010, stall=1. exc_ack gives flush=1 for one cycle, then IDLE and exc_count=1.
- Priority: ALU_status_in=8'h4C -> exc_cause=2. A second status_valid (8'h04, new PC) while PENDING -> epc and status_reg unchanged.
- Mask: en_we with en_wdata=8'h08 in the same cycle as overflow status 8'h40 -> exception taken (old mask). A later 8'h40 -> no exception, sticky_flags[6]=1.
- Reset mid-PENDING: drive rst_n low with exc_req=1 -> all outputs 0 asynchronously, exc_en=8'h4C, and no flush pulse.
- Saturation and sticky clear: 260 exceptions -> exc_count=255. sticky_clr together with status 8'h20 -> sticky_flags=8'h20.
